// File: rtl/conv_encoder_bs.sv
// Byte-serial rate-1/3 tail-biting convolutional encoder, K=7, generators 133/171/165 (octal).
// Optional feature macro: CONV_ENC_LONG_BLOCK_EN enables 768-byte blocks via code_block_length.
module conv_encoder_bs (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_valid,
    input  logic [7:0] tail_byte,
    input  logic       code_block_length,
    input  logic       blk_empty,
    input  logic [7:0] blk_data,
    output logic       blk_data_rdreq,
    input  logic       rdreq_subblock,
    output logic [7:0] q0,
    output logic [7:0] q1,
    output logic [7:0] q2,
    output logic       computation_done,
    output logic       length_out
);

`ifdef CONV_ENC_LONG_BLOCK_EN
    localparam int unsigned DEPTH   = 768;
    localparam int unsigned CW      = 10;
    localparam int unsigned LONG_N  = 768;
`else
    localparam int unsigned DEPTH   = 132;
    localparam int unsigned CW      = 8;
`endif
    localparam int unsigned SHORT_N = 132;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DONE,
        ST_OUT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          start;
    logic          rd_accept;
    logic          rd_pend;
    logic [5:0]    sr;
    logic [5:0]    sr_nxt;
    logic [7:0]    enc_d0;
    logic [7:0]    enc_d1;
    logic [7:0]    enc_d2;
    logic [CW-1:0] req_cnt;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_idx;
    logic [CW-1:0] blk_n;
    logic [CW-1:0] last_idx;
    logic          unused_in;

    logic [7:0] buf_d0 [DEPTH];
    logic [7:0] buf_d1 [DEPTH];
    logic [7:0] buf_d2 [DEPTH];

`ifdef CONV_ENC_LONG_BLOCK_EN
    logic long_q;

    // Block length is frozen at start so a changing port cannot corrupt a block in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            long_q <= 1'b0;
        end else if (start) begin
            long_q <= code_block_length;
        end
    end

    assign blk_n      = long_q ? CW'(LONG_N) : CW'(SHORT_N);
    assign length_out = long_q;
    assign unused_in  = ^tail_byte[7:6];
`else
    assign blk_n      = CW'(SHORT_N);
    assign length_out = 1'b0;
    assign unused_in  = ^{tail_byte[7:6], code_block_length};
`endif

    assign last_idx = blk_n - CW'(1);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and FIFO/readout handshakes
    always_comb begin
        state_nxt      = state;
        blk_data_rdreq = 1'b0;
        start          = 1'b0;
        rd_accept      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (data_valid) begin
                    start     = 1'b1;
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                blk_data_rdreq = !blk_empty && (req_cnt != blk_n);
                if (rd_pend && (wr_cnt == last_idx)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (rdreq_subblock) begin
                    rd_accept = 1'b1;
                    if (rd_idx == last_idx) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Eight trellis steps per byte; sr[0] is D1 (most recent bit), sr[5] is D6.
    always_comb begin
        logic [5:0] st;
        logic       c;
        enc_d0 = '0;
        enc_d1 = '0;
        enc_d2 = '0;
        st     = sr;
        c      = 1'b0;
        for (int k = 0; k < 8; k++) begin
            c             = blk_data[7-k];
            enc_d0[7-k]   = c ^ st[1] ^ st[2] ^ st[4] ^ st[5];
            enc_d1[7-k]   = c ^ st[0] ^ st[1] ^ st[2] ^ st[5];
            enc_d2[7-k]   = c ^ st[0] ^ st[1] ^ st[3] ^ st[5];
            st            = {st[4:0], c};
        end
        sr_nxt = st;
    end

    // Encoder state, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr               <= '0;
            req_cnt          <= '0;
            wr_cnt           <= '0;
            rd_idx           <= '0;
            rd_pend          <= 1'b0;
            computation_done <= 1'b0;
            q0               <= '0;
            q1               <= '0;
            q2               <= '0;
        end else begin
            rd_pend          <= blk_data_rdreq;
            computation_done <= (state == ST_DONE);
            if (start) begin
                sr      <= tail_byte[5:0];
                req_cnt <= '0;
                wr_cnt  <= '0;
                rd_idx  <= '0;
            end
            if (blk_data_rdreq) begin
                req_cnt <= req_cnt + CW'(1);
            end
            if (rd_pend) begin
                sr     <= sr_nxt;
                wr_cnt <= wr_cnt + CW'(1);
            end
            if (rd_accept) begin
                q0     <= buf_d0[rd_idx];
                q1     <= buf_d1[rd_idx];
                q2     <= buf_d2[rd_idx];
                rd_idx <= rd_idx + CW'(1);
            end
        end
    end

    // Parity stream buffers, written at the byte count of the data being consumed
    always_ff @(posedge clk) begin
        if (rd_pend) begin
            buf_d0[wr_cnt] <= enc_d0;
            buf_d1[wr_cnt] <= enc_d1;
            buf_d2[wr_cnt] <= enc_d2;
        end
    end

endmodule

// File: tb/tb_conv_encoder_bs.sv
// Self-checking bench for conv_encoder_bs: table of block scenarios, generator-polynomial
// reference model feeding a scoreboard queue, plus stall / busy-start / mid-block reset cases.
module tb_conv_encoder_bs;
    localparam int unsigned NB = 132;

    logic       clk = 1'b0;
    logic       reset;
    logic       data_valid;
    logic [7:0] tail_byte;
    logic       code_block_length;
    logic       blk_empty;
    logic [7:0] blk_data = '0;
    logic       blk_data_rdreq;
    logic       rdreq_subblock;
    logic [7:0] q0, q1, q2;
    logic       computation_done;
    logic       length_out;

    conv_encoder_bs dut (
        .clk              (clk),
        .reset            (reset),
        .data_valid       (data_valid),
        .tail_byte        (tail_byte),
        .code_block_length(code_block_length),
        .blk_empty        (blk_empty),
        .blk_data         (blk_data),
        .blk_data_rdreq   (blk_data_rdreq),
        .rdreq_subblock   (rdreq_subblock),
        .q0               (q0),
        .q1               (q1),
        .q2               (q2),
        .computation_done (computation_done),
        .length_out       (length_out)
    );

    always #5 clk = ~clk;

    // Show-behind FIFO model: data appears the cycle after the read request
    logic [7:0] mem [NB];
    int         ptr = NB;
    logic       fifo_clr;
    logic       stall;
    assign blk_empty = stall || (ptr >= NB);

    always @(posedge clk) begin
        if (fifo_clr) begin
            ptr <= 0;
        end else if (blk_data_rdreq) begin
            blk_data <= mem[ptr];
            ptr      <= ptr + 1;
        end
    end

    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (computation_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    typedef struct packed {
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
    } trip_t;
    trip_t sb[$];

    typedef struct {
        logic [7:0] first;
        logic [7:0] last;
        bit         rnd;
        int         stall_at;
        bit         busy;
        bit         chk;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] e2;
        string      name;
    } vec_t;
    vec_t vt[6];

    int checks = 0;
    int errors = 0;

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    // Reference: window {c, D1..D6} masked with the octal generators
    task automatic model_push();
        logic [5:0] s;
        logic [6:0] w;
        trip_t      t;
        logic [7:0] tb;
        tb = mem[NB-1];
        for (int i = 0; i < 6; i++) s[5-i] = tb[i];
        for (int b = 0; b < NB; b++) begin
            t = '0;
            for (int k = 0; k < 8; k++) begin
                w          = {mem[b][7-k], s};
                t.d0[7-k]  = ^(w & 7'o133);
                t.d1[7-k]  = ^(w & 7'o171);
                t.d2[7-k]  = ^(w & 7'o165);
                s          = w[6:1];
            end
            sb.push_back(t);
        end
    endtask

    task automatic run_block(input int vi, input bit abort);
        vec_t  v;
        int    d0;
        int    start_cyc;
        int    stall_rd;
        int    exp_lat;
        trip_t t;
        trip_t last_t;
        v = vt[vi];
        for (int i = 0; i < NB; i++) mem[i] = v.rnd ? 8'($urandom) : 8'h00;
        if (!v.rnd) begin
            mem[0]    = v.first;
            mem[NB-1] = v.last;
        end
        if (!abort) model_push();

        @(negedge clk) fifo_clr = 1'b1;
        @(negedge clk) fifo_clr = 1'b0;
        d0                = done_cnt;
        data_valid        = 1'b1;
        tail_byte         = mem[NB-1];
        code_block_length = 1'b0;
`ifndef CONV_ENC_LONG_BLOCK_EN
        code_block_length = v.rnd;
`endif
        start_cyc = cyc;
        @(negedge clk);
        data_valid = 1'b0;
        check_int({v.name, "_first_rdreq"}, int'(blk_data_rdreq), 1);
`ifndef CONV_ENC_LONG_BLOCK_EN
        check_int({v.name, "_length_out"}, int'(length_out), 0);
`endif

        if (abort) begin
            repeat (40) @(negedge clk);
            reset = 1'b0;
            #1;
            check8("rst_q0", q0, 8'h00);
            check8("rst_q1", q1, 8'h00);
            check8("rst_q2", q2, 8'h00);
            check_int("rst_done", int'(computation_done), 0);
            check_int("rst_rdreq", int'(blk_data_rdreq), 0);
            check_int("rst_length", int'(length_out), 0);
            @(negedge clk);
            reset = 1'b1;
            return;
        end

        if (v.busy) begin
            repeat (5) @(negedge clk);
            data_valid     = 1'b1;
            tail_byte      = ~tail_byte;
            rdreq_subblock = 1'b1;
            @(negedge clk);
            data_valid     = 1'b0;
            rdreq_subblock = 1'b0;
        end

        exp_lat = 135;
        if (v.stall_at > 0) begin
            for (int k = 0; k < 500 && ptr < v.stall_at; k++) @(negedge clk);
            stall    = 1'b1;
            stall_rd = 0;
            for (int k = 0; k < 10; k++) begin
                #1;
                if (blk_data_rdreq) stall_rd++;
                @(negedge clk);
            end
            stall = 1'b0;
            check_int({v.name, "_rdreq_in_stall"}, stall_rd, 0);
            exp_lat = 145;
        end

        for (int k = 0; k < 3000 && done_cnt == d0; k++) @(negedge clk);
        check_int({v.name, "_done_seen"}, int'(done_cnt != d0), 1);
        check_int({v.name, "_done_latency"}, done_cyc - start_cyc, exp_lat);
        repeat (3) @(negedge clk);
        check_int({v.name, "_done_pulses"}, done_cnt - d0, 1);

        rdreq_subblock = 1'b1;
        last_t = '0;
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                check_int({v.name, "_sb_underflow"}, 1, 0);
            end else begin
                t = sb.pop_front();
                last_t = t;
                check8($sformatf("%s_q0[%0d]", v.name, i), q0, t.d0);
                check8($sformatf("%s_q1[%0d]", v.name, i), q1, t.d1);
                check8($sformatf("%s_q2[%0d]", v.name, i), q2, t.d2);
            end
            if (i == 0 && v.chk) begin
                check8({v.name, "_tbl_q0"}, q0, v.e0);
                check8({v.name, "_tbl_q1"}, q1, v.e1);
                check8({v.name, "_tbl_q2"}, q2, v.e2);
            end
        end
        @(negedge clk);
        rdreq_subblock = 1'b0;
        check8({v.name, "_hold_q0"}, q0, last_t.d0);
        check8({v.name, "_hold_q2"}, q2, last_t.d2);
    endtask

    initial begin
        reset             = 1'b0;
        data_valid        = 1'b0;
        tail_byte         = '0;
        code_block_length = 1'b0;
        rdreq_subblock    = 1'b0;
        stall             = 1'b0;
        fifo_clr          = 1'b0;

        vt[0] = '{8'h00, 8'h00, 1'b0, 0,  1'b0, 1'b1, 8'h00, 8'h00, 8'h00, "zero"};
        vt[1] = '{8'h80, 8'h00, 1'b0, 0,  1'b0, 1'b1, 8'hB6, 8'hF2, 8'hEA, "impulse"};
        vt[2] = '{8'h00, 8'h01, 1'b0, 0,  1'b0, 1'b1, 8'h6C, 8'hE4, 8'hD4, "tailbite"};
        vt[3] = '{8'h80, 8'h00, 1'b0, 50, 1'b0, 1'b1, 8'hB6, 8'hF2, 8'hEA, "stall"};
        vt[4] = '{8'h00, 8'h01, 1'b0, 0,  1'b1, 1'b1, 8'h6C, 8'hE4, 8'hD4, "busy"};
        vt[5] = '{8'h00, 8'h00, 1'b1, 0,  1'b0, 1'b0, 8'h00, 8'h00, 8'h00, "random"};

        #1;
        check8("reset_q0", q0, 8'h00);
        check8("reset_q1", q1, 8'h00);
        check8("reset_q2", q2, 8'h00);
        check_int("reset_done", int'(computation_done), 0);
        check_int("reset_rdreq", int'(blk_data_rdreq), 0);
        check_int("reset_length", int'(length_out), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int vi = 0; vi < 6; vi++) run_block(vi, 1'b0);
        run_block(5, 1'b1);
        run_block(1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
